// File: rtl/vga_scan_timing_if.sv
// vga_scan_timing_if: raster timing outputs produced by vga_scan_timing.
// The frameCount signal exists only when VGA_SCAN_TIMING_FRAMECNT_EN is defined.
interface vga_scan_timing_if;
    logic        pixEn;
    logic [8:0]  curRow;
    logic [9:0]  curCol;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic        lineStart;
    logic        frameStart;
`ifdef VGA_SCAN_TIMING_FRAMECNT_EN
    logic [15:0] frameCount;

    modport master (
        output pixEn, curRow, curCol, active, hsync, vsync,
               lineStart, frameStart, frameCount
    );
    modport slave (
        input  pixEn, curRow, curCol, active, hsync, vsync,
               lineStart, frameStart, frameCount
    );
`else
    modport master (
        output pixEn, curRow, curCol, active, hsync, vsync,
               lineStart, frameStart
    );
    modport slave (
        input  pixEn, curRow, curCol, active, hsync, vsync,
               lineStart, frameStart
    );
`endif
endinterface

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: pixel-rate divider plus horizontal/vertical raster counters
// driving registered coordinates, sync and blanking for the VGA text path.
// Optional frame counter output enabled by defining VGA_SCAN_TIMING_FRAMECNT_EN.
module vga_scan_timing #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic              clk,
    input  logic              reset,
    vga_scan_timing_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcnt;
    logic [9:0]       r_vcnt;
    logic             r_pixEn;
    logic [8:0]       r_curRow;
    logic [9:0]       r_curCol;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_lineStart;
    logic             r_frameStart;

    logic [DIV_W-1:0] w_div_next;
    logic             w_tick;
    logic [9:0]       w_hcnt_next;
    logic [9:0]       w_vcnt_next;
    logic             w_active;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_line;
    logic             w_frame;

    // Next divider/counter values and the output decode of the advanced position.
    // The tick is taken from the next divider value so pixEn, the counters and
    // every decoded output all change on the same edge.
    always_comb begin
        w_div_next  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        w_tick      = (w_div_next == DIV_LAST);
        w_hcnt_next = r_hcnt + 10'd1;
        w_vcnt_next = r_vcnt;
        if (r_hcnt == H_LAST) begin
            w_hcnt_next = '0;
            w_vcnt_next = (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
        end
        w_active = (w_hcnt_next < H_ACT) && (w_vcnt_next < V_ACT);
        w_hsync  = !((w_hcnt_next >= H_SYNC_BEG) && (w_hcnt_next < H_SYNC_END));
        w_vsync  = !((w_vcnt_next >= V_SYNC_BEG) && (w_vcnt_next < V_SYNC_END));
        w_line   = (w_hcnt_next == '0);
        w_frame  = w_line && (w_vcnt_next == '0);
    end

    // Divider, raster counters and registered outputs; outputs hold between
    // ticks except the start pulses, which last a single clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_hcnt       <= H_LAST;
            r_vcnt       <= V_LAST;
            r_pixEn      <= 1'b0;
            r_curRow     <= '0;
            r_curCol     <= '0;
            r_active     <= 1'b0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_div   <= w_div_next;
            r_pixEn <= w_tick;
            if (w_tick) begin
                r_hcnt       <= w_hcnt_next;
                r_vcnt       <= w_vcnt_next;
                r_active     <= w_active;
                r_hsync      <= w_hsync;
                r_vsync      <= w_vsync;
                r_curCol     <= w_active ? w_hcnt_next : '0;
                r_curRow     <= w_active ? w_vcnt_next[8:0] : '0;
                r_lineStart  <= w_line;
                r_frameStart <= w_frame;
            end else begin
                r_lineStart  <= 1'b0;
                r_frameStart <= 1'b0;
            end
        end
    end

    assign bus.pixEn      = r_pixEn;
    assign bus.curRow     = r_curRow;
    assign bus.curCol     = r_curCol;
    assign bus.active     = r_active;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.lineStart  = r_lineStart;
    assign bus.frameStart = r_frameStart;

`ifdef VGA_SCAN_TIMING_FRAMECNT_EN
    logic [15:0] r_frameCount;

    // Frame counter advancing on every frameStart tick, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frameCount <= '0;
        end else if (w_tick && w_frame) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

    assign bus.frameCount = r_frameCount;
`endif
endmodule
